// File: rtl/mult_accum_seq_if.sv
// Operand/result bundle for mult_accum_seq: operand stream in, multiplier
// operands out, product back, and the accumulated result handshake.
interface mult_accum_seq_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  // master = environment (operand source, multiplier, result sink)
  modport master (
    output in_valid, in_a, in_b, in_last, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_acc, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/mult_accum_seq.sv
// Sequencer/accumulator around an external 4x4 combinational multiplier:
// registers operand pairs, sums returned products, hands off total on last.
module mult_accum_seq #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  mult_accum_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [3:0]       mul_a_reg;
  logic [3:0]       mul_b_reg;
  logic             pend_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic             accept;
  logic [ACC_W:0]   sum_next;
  logic [CNT_W-1:0] cnt_next;

  // in_ready is a function of registered state and ena only
  assign bus.in_ready = ena && (state_reg == RUN);
  assign accept       = bus.in_valid && bus.in_ready;

  // Extra top bit of the sum is the carry-out that feeds the sticky overflow
  assign sum_next = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, bus.mul_p};
  assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      pend_reg      <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (ena) begin
      pend_reg <= accept;
      if (accept) begin
        mul_a_reg <= bus.in_a;
        mul_b_reg <= bus.in_b;
      end
      // Product of the previous accept is added on the same edge that may load the next pair
      if (pend_reg) begin
        acc_reg <= sum_next[ACC_W-1:0];
        ovf_reg <= ovf_reg | sum_next[ACC_W];
        cnt_reg <= cnt_next;
      end
      case (state_reg)
        RUN: begin
          if (accept && bus.in_last) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          // pend is always clear here, so the clear cannot collide with an add
          if (bus.out_ready) begin
            state_reg     <= RUN;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg     <= RUN;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_acc   = acc_reg;
  assign bus.out_cnt   = cnt_reg;
  assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_mult_accum_seq.sv
// Scoreboard bench for mult_accum_seq: two instances (16/4 and 9/2 widths)
// share one stimulus stream; a monitor checks each result handoff.
module tb_mult_accum_seq;

  localparam int AW_L = 16;
  localparam int CW_L = 4;
  localparam int AW_S = 9;
  localparam int CW_S = 2;

  typedef struct {
    longint acc_l;
    longint cnt_l;
    longint ovf_l;
    longint acc_s;
    longint cnt_s;
    longint ovf_s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       out_ready;

  int ena_mode;
  int rdy_mode;
  int n_cmp = 0;
  int n_mis = 0;
  exp_t sb[$];
  logic [3:0] op_a[16];
  logic [3:0] op_b[16];

  mult_accum_seq_if #(.ACC_W(AW_L), .CNT_W(CW_L)) bus_l ();
  mult_accum_seq_if #(.ACC_W(AW_S), .CNT_W(CW_S)) bus_s ();

  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_a      = in_a;
  assign bus_l.in_b      = in_b;
  assign bus_l.in_last   = in_last;
  assign bus_l.out_ready = out_ready;
  assign bus_l.mul_p     = {4'b0, bus_l.mul_a} * {4'b0, bus_l.mul_b};
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_a      = in_a;
  assign bus_s.in_b      = in_b;
  assign bus_s.in_last   = in_last;
  assign bus_s.out_ready = out_ready;
  assign bus_s.mul_p     = {4'b0, bus_s.mul_a} * {4'b0, bus_s.mul_b};

  mult_accum_seq #(.ACC_W(AW_L), .CNT_W(CW_L)) dut_l (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus_l)
  );
  mult_accum_seq #(.ACC_W(AW_S), .CNT_W(CW_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Reference: the sum of products reduced to the result width; any wrap of a
  // monotonically growing sum means the total reached 2^ACC_W
  function automatic exp_t model(input longint total, input int n);
    exp_t e;
    e.acc_l = total % (longint'(1) << AW_L);
    e.ovf_l = (total >= (longint'(1) << AW_L)) ? 1 : 0;
    e.cnt_l = (n > (1 << CW_L) - 1) ? (1 << CW_L) - 1 : n;
    e.acc_s = total % (longint'(1) << AW_S);
    e.ovf_s = (total >= (longint'(1) << AW_S)) ? 1 : 0;
    e.cnt_s = (n > (1 << CW_S) - 1) ? (1 << CW_S) - 1 : n;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accept edge
  task automatic drive_pair(input logic [3:0] a, input logic [3:0] b,
                            input logic last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (bus_l.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 500) begin
        n_cmp++;
        n_mis++;
        $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", waited);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_sum(input int n, input int gap_max);
    longint total = 0;
    int w;
    for (int i = 0; i < n; i++) total += longint'(op_a[i]) * longint'(op_b[i]);
    sb.push_back(model(total, n));
    for (int i = 0; i < n; i++) begin
      drive_pair(op_a[i], op_b[i], (i == n - 1), w);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (sb.size() != 0 || bus_l.out_valid) begin
      b++;
      if (b > 300) begin
        n_cmp++;
        n_mis++;
        $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    ena = 1'b1;
    forever begin
      @(posedge clk); #2;
      ena = (ena_mode == 1) || (ena_mode == 2 && $urandom_range(0, 5) != 0);
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
    end
  end

  // Monitor: a result handoff completes on the edge after a negedge that sees it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ena && bus_l.out_valid && bus_l.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("acc16", bus_l.out_acc, e.acc_l);
          check("cnt4", bus_l.out_cnt, e.cnt_l);
          check("ovf16", bus_l.out_ovf, e.ovf_l);
          check("valid9", bus_s.out_valid, 1);
          check("acc9", bus_s.out_acc, e.acc_s);
          check("cnt2", bus_s.out_cnt, e.cnt_s);
          check("ovf9", bus_s.out_ovf, e.ovf_s);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    ena_mode = 1; rdy_mode = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus_l.in_ready, 1);
    check("rst_mul_a", bus_l.mul_a, 0);
    check("rst_mul_b", bus_l.mul_b, 0);
    check("rst_out_valid", bus_l.out_valid, 0);
    check("rst_out_acc", bus_l.out_acc, 0);
    check("rst_out_cnt", bus_l.out_cnt, 0);
    check("rst_out_ovf", bus_l.out_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single term 15*15 with a 10-cycle hold in DONE
    op_a[0] = 15; op_b[0] = 15;
    run_sum(1, 0);
    check("single_mul_a", bus_l.mul_a, 15);
    check("single_mul_b", bus_l.mul_b, 15);
    @(negedge clk);
    check("drain_out_valid", bus_l.out_valid, 0);
    check("drain_in_ready", bus_l.in_ready, 0);
    @(negedge clk);
    check("done_out_valid", bus_l.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", bus_l.out_valid, 1);
      check("hold_in_ready", bus_l.in_ready, 0);
      check("hold_acc", bus_l.out_acc, 225);
      check("hold_cnt", bus_l.out_cnt, 1);
      check("hold_ovf", bus_l.out_ovf, 0);
    end
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    check("handoff_in_ready", bus_l.in_ready, 1);
    check("handoff_out_valid", bus_l.out_valid, 0);
    @(posedge clk); #1;

    // Back-to-back pairs with in_valid held high
    sb.push_back(model(98, 3));
    drive_pair(3, 4, 1'b0, w); check("b2b_wait0", w, 0);
    drive_pair(5, 6, 1'b0, w); check("b2b_wait1", w, 0);
    drive_pair(7, 8, 1'b1, w); check("b2b_wait2", w, 0);
    @(negedge clk);
    check("b2b_in_ready_low", bus_l.in_ready, 0);
    @(posedge clk); #1;
    wait_idle();

    // Overflow on the narrow instance and count saturation
    for (int i = 0; i < 2; i++) begin op_a[i] = 15; op_b[i] = 15; end
    run_sum(2, 0); wait_idle();
    for (int i = 0; i < 3; i++) begin op_a[i] = 15; op_b[i] = 15; end
    run_sum(3, 0); wait_idle();
    for (int i = 0; i < 5; i++) begin op_a[i] = 1; op_b[i] = 1; end
    run_sum(5, 0); wait_idle();

    // ena dropped with a product pending and the next pair offered
    sb.push_back(model(26, 3));
    drive_pair(3, 5, 1'b0, w);
    ena_mode = 0;
    in_valid = 1'b1; in_a = 2; in_b = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("freeze_in_ready", bus_l.in_ready, 0);
      check("freeze_acc", bus_l.out_acc, 0);
      check("freeze_cnt", bus_l.out_cnt, 0);
      check("freeze_mul_a", bus_l.mul_a, 3);
    end
    ena_mode = 1;
    @(posedge clk); #1;
    drive_pair(2, 2, 1'b0, w);
    drive_pair(1, 7, 1'b1, w);
    wait_idle();

    // Reset while in DRAIN with a nonzero partial sum
    op_a[0] = 9; op_b[0] = 9; op_a[1] = 9; op_b[1] = 9;
    run_sum(2, 0);
    rst_n = 1'b0;
    #1;
    check("rstd_in_ready", bus_l.in_ready, 1);
    check("rstd_out_valid", bus_l.out_valid, 0);
    check("rstd_acc", bus_l.out_acc, 0);
    check("rstd_cnt", bus_l.out_cnt, 0);
    check("rstd_mul_a", bus_l.mul_a, 0);
    check("rstd_mul_b", bus_l.mul_b, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_a[0] = 2; op_b[0] = 3; op_a[1] = 4; op_b[1] = 5;
    run_sum(2, 0); wait_idle();

    // Randomized sums with random ena, out_ready and input gaps
    ena_mode = 2; rdy_mode = 2;
    for (int s = 0; s < 40; s++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        op_a[i] = 4'($urandom_range(0, 15));
        op_b[i] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      end
      run_sum(n, 2);
    end
    ena_mode = 1; rdy_mode = 1;
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mult_accum_seq.md
# mult_accum_seq

Sequencing and accumulation stage wrapped around the 4x4 combinational array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair onto the multiplier inputs. It sums the returned 8-bit products into an accumulator and emits the total, a term count and an overflow flag when the pair marked last has been accumulated.

## Interface
- ACC_W, 16, accumulator/result width; legal range 9..32.
- CNT_W, 4, term-counter width; legal range 1..8.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low freezes all state.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  4  multiplicand.
- in_b  input  4  multiplier.
- in_last  input  1  pair is the final term of the current sum.
- mul_a  output  4  registered operand to the multiplier a input.
- mul_b  output  4  registered operand to the multiplier b input.
- mul_p  input  8  combinational product returned from the multiplier.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  accumulated sum.
- out_cnt  output  CNT_W  number of terms in the sum; saturates.
- out_ovf  output  1  sticky flag: the sum exceeded ACC_W bits.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset state is RUN.
- A pair is accepted when in_valid & in_ready & ena.
- RUN: in_ready=1.
  - Each accept loads mul_a<=in_a and mul_b<=in_b, and sets the internal pend flag.
  - If in_last is set on the accept, go to DRAIN.
- pend:
  - Set for one cycle after an accept.
  - While pend=1, the next enabled edge performs acc<=acc+mul_p (modulo 2^ACC_W).
  - The same edge sets ovf on carry-out and increments cnt, saturating at 2^CNT_W-1.
  - Back-to-back accepts are legal. The add of term n and the load of term n+1 happen on the same edge.
- DRAIN: in_ready=0. The pending add completes, then the FSM goes to DONE.
- DONE: in_ready=0 and out_valid=1.
  - out_acc, out_cnt and out_ovf hold stable.
  - On out_ready & ena: acc<=0, cnt<=0, ovf<=0, go to RUN.
- ena=0: no handshakes complete, in_ready is forced to 0, and no register changes. out_valid holds its current value.
- mul_a and mul_b hold their last value between accepts. They are not cleared on result handoff.
- Reset mid-operation, at any state: immediate return to RUN with acc=0, cnt=0, ovf=0, pend=0. Any in-flight term is discarded.
- Reset values: in_ready=1 (when ena=1), mul_a=0, mul_b=0, out_valid=0, out_acc=0, out_cnt=0, out_ovf=0.
- out_acc, out_cnt and out_ovf are live views of the accumulator registers. They are meaningful only while out_valid=1.

## Timing
- Accept at edge k: mul_a/mul_b update at edge k, and the product is added at edge k+1.
- Last pair accepted at edge k:
  - The FSM enters DRAIN at edge k.
  - The FSM enters DONE at edge k+1, so out_valid is high in the cycle following edge k+1.
  - Minimum latency from last accept to result is 2 edges.
- Throughput: one pair per cycle in RUN.
- Dead time between sums: DRAIN (1 cycle) plus the DONE cycles, plus 0 cycles after the out_ready handshake. The first accept of the next sum can occur in the cycle after the handoff edge.
- A single-term sum (first pair carries in_last) follows the same timing with out_cnt=1.
- in_ready depends only on registered state and ena; there is no combinational in_valid->in_ready path.
- out_valid is a registered output.

## Test plan
- Reset then a single pair a=15, b=15, last=1 -> out_valid 2 edges later with out_acc=225, out_cnt=1, out_ovf=0; mul_a=15, mul_b=15.
- Back-to-back pairs (3,4),(5,6),(7,8 last) with in_valid continuously high -> in_ready=1 for 3 cycles, then 0; out_acc=12+30+56=98, out_cnt=3.
- ACC_W=9, pairs (15,15),(15,15 last) -> out_acc=450 mod 512=450, ovf=0; a third (15,15) term -> out_acc=675-512=163, out_ovf=1.
- CNT_W=2, five pairs (1,1) -> out_acc=5, out_cnt=3 (saturated).
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 -> next cycle in_ready=1 and the accumulator reads 0 on the next sum.
- Drop ena mid-stream and assert rst_n=0 while in DRAIN:
  - ena low -> in_ready=0 and no acc change.
  - rst_n low -> outputs return immediately to their reset values, and the following sum is uncorrupted.
